// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_slave block.
//   i2c_state_e : byte-level FSM states of the target
//   i2c_dbg_t   : observability bundle exported by the top (FSM state,
//                 bit counter, conditioned SCL/SDA)
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } i2c_state_e;

  localparam logic I2C_RW_WRITE  = 1'b0;
  localparam logic I2C_RW_READ   = 1'b1;
  localparam int   I2C_BYTE_BITS = 8;

  typedef struct packed {
    i2c_state_e state;
    logic [2:0] bit_cnt;
    logic       s_scl;
    logic       s_sda;
  } i2c_dbg_t;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus and fabric signals of the i2c_slave target, grouped in one bundle.
//   scl_in/sda_in : pad inputs (asynchronous)
//   sda_oe        : 1 pulls SDA low (open drain), 0 releases it
//   rx_*          : written bytes delivered to the fabric
//   tx_*          : read bytes fetched from the fabric
//   busy/start_det/stop_det : bus status
// Handshake: rx_valid is a one-cycle strobe with rx_data/rx_first stable in
// that cycle, there is no back-pressure. tx_req is a one-cycle strobe;
// the fabric answers with a one-cycle tx_valid carrying tx_data, and a
// tx_valid with no request outstanding is dropped.
interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  scl_in, sda_in, tx_data, tx_valid,
    output sda_oe, rx_data, rx_valid, rx_first, tx_req, busy, start_det, stop_det
  );

  modport master (
    output scl_in, sda_in, tx_data, tx_valid,
    input  sda_oe, rx_data, rx_valid, rx_first, tx_req, busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_line_cond.sv
// Line conditioning for the I2C target: synchronizer, optional glitch
// filter, SCL edge detection and START/STOP detection.
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN adds a FILTER_LEN-deep
// agreement filter after the synchronizer.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   scl_in, sda_in    : asynchronous pad inputs
//   s_scl, s_sda      : conditioned line levels
//   scl_rise/scl_fall : one-cycle SCL edge strobes
//   start/stop        : one-cycle START / STOP strobes
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic s_scl,
  output logic s_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_param
    $error("i2c_line_cond: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  // Preset to 1 so a reset looks like an idle bus, not a spurious edge.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Output follows the input only after FILTER_LEN identical samples.
  logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                  scl_filt_q, sda_filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= (scl_hist_q << 1) | FILTER_LEN'(scl_sync_q[SYNC_STAGES-1]);
      sda_hist_q <= (sda_hist_q << 1) | FILTER_LEN'(sda_sync_q[SYNC_STAGES-1]);
      if (&scl_hist_q)       scl_filt_q <= 1'b1;
      else if (~|scl_hist_q) scl_filt_q <= 1'b0;
      if (&sda_hist_q)       sda_filt_q <= 1'b1;
      else if (~|sda_hist_q) sda_filt_q <= 1'b0;
    end
  end

  assign s_scl = scl_filt_q;
  assign s_sda = sda_filt_q;
`else
  assign s_scl = scl_sync_q[SYNC_STAGES-1];
  assign s_sda = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= s_scl;
      sda_prev_q <= s_sda;
    end
  end

  assign scl_rise = s_scl & ~scl_prev_q;
  assign scl_fall = ~s_scl & scl_prev_q;
  // SCL must be high in both samples so an SDA change racing an SCL edge
  // is never mistaken for a bus condition.
  assign start    = s_scl & scl_prev_q & sda_prev_q & ~s_sda;
  assign stop     = s_scl & scl_prev_q & ~sda_prev_q & s_sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match + ACK, write bytes to the fabric, read bytes
// from the fabric via tx_req/tx_valid.
// Optional feature macro: I2C_SLAVE_GLITCH_FILTER_EN (see i2c_line_cond).
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   bus        : i2c_slave_if.slave (pads, rx/tx fabric handshake, status)
//   dbg_o      : FSM state, bit counter and conditioned lines
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h4B,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic              clk,
  input  logic              reset,
  i2c_slave_if.slave        bus,
  output i2c_dbg_t          dbg_o
);

  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

  logic s_scl, s_sda, scl_rise, scl_fall, start, stop;

  i2c_line_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_line_cond (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (bus.scl_in),
    .sda_in   (bus.sda_in),
    .s_scl    (s_scl),
    .s_sda    (s_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic       rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d, start_det_q, start_det_d, stop_det_q, stop_det_d;
  logic       rw_q, rw_d, first_q, first_d;   // R/W bit, next write byte is the pointer
  logic       ack_on_q, ack_on_d;             // ACK currently driven
  logic       fresh_q, fresh_d;               // next fall in RD_BYTE drives bit 7
  logic       tx_pend_q, tx_pend_d;           // tx_req outstanding
  logic       tx_loaded_q, tx_loaded_d;       // shift_q holds the fabric byte
  logic [7:0] in_byte, rd_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      rw_q        <= I2C_RW_WRITE;
      first_q     <= 1'b0;
      ack_on_q    <= 1'b0;
      fresh_q     <= 1'b0;
      tx_pend_q   <= 1'b0;
      tx_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      ack_on_q    <= ack_on_d;
      fresh_q     <= fresh_d;
      tx_pend_q   <= tx_pend_d;
      tx_loaded_q <= tx_loaded_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    first_d     = first_q;
    ack_on_d    = ack_on_q;
    fresh_d     = fresh_q;
    tx_pend_d   = tx_pend_q;
    tx_loaded_d = tx_loaded_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    in_byte     = {shift_q[6:0], s_sda};
    // Byte to send: fabric data if it has arrived (even this very cycle),
    // otherwise all ones, which leaves SDA released for the whole byte.
    rd_byte     = tx_loaded_q ? shift_q
                : ((tx_pend_q && bus.tx_valid) ? bus.tx_data : 8'hFF);

    if (tx_pend_q && bus.tx_valid) begin
      shift_d     = bus.tx_data;
      tx_loaded_d = 1'b1;
      tx_pend_d   = 1'b0;
    end

    if (start) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      ack_on_d    = 1'b0;
      tx_pend_d   = 1'b0;
      tx_loaded_d = 1'b0;
      start_det_d = 1'b1;
    end else if (stop) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      tx_pend_d   = 1'b0;
      tx_loaded_d = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            if (in_byte[7:1] == SLAVE_ADDR) begin
              busy_d   = 1'b1;
              rw_d     = in_byte[0];
              ack_on_d = 1'b0;
              state_d  = ADDR_ACK;
            end else begin
              state_d  = IDLE;
            end
          end
        end
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_on_q) begin
            sda_oe_d = 1'b1;
            ack_on_d = 1'b1;
            if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
              tx_req_d    = 1'b1;
              tx_pend_d   = 1'b1;
              tx_loaded_d = 1'b0;
            end
          end else begin
            ack_on_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
              // The fall ending the ACK is also where bit 7 goes out.
              state_d     = RD_BYTE;
              sda_oe_d    = ~rd_byte[7];
              shift_d     = rd_byte;
              tx_pend_d   = 1'b0;
              tx_loaded_d = 1'b0;
              fresh_d     = 1'b0;
            end else begin
              state_d  = WR_BYTE;
              sda_oe_d = 1'b0;
              if (state_q == ADDR_ACK) first_d = 1'b1;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = in_byte;
            rx_valid_d = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            ack_on_d   = 1'b0;
            state_d    = WR_ACK;
          end
        end
        // bit_cnt counts the falls after bit 7; the 8th fall releases SDA.
        RD_BYTE: if (scl_fall) begin
          if (fresh_q) begin
            sda_oe_d    = ~rd_byte[7];
            shift_d     = rd_byte;
            tx_pend_d   = 1'b0;
            tx_loaded_d = 1'b0;
            fresh_d     = 1'b0;
            bit_cnt_d   = '0;
          end else if (bit_cnt_q == LAST_BIT) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = RD_ACK;
          end else begin
            sda_oe_d  = ~shift_q[6];
            shift_d   = {shift_q[6:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!s_sda) begin
            tx_req_d    = 1'b1;
            tx_pend_d   = 1'b1;
            tx_loaded_d = 1'b0;
            fresh_d     = 1'b1;
            state_d     = RD_BYTE;
          end else begin
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_first  = rx_first_q;
  assign bus.tx_req    = tx_req_q;
  assign bus.busy      = busy_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;

  assign dbg_o = '{state: state_q, bit_cnt: bit_cnt_q, s_scl: s_scl, s_sda: s_sda};

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master, a fabric responder for
// tx_req, and a monitor that checks every rx_valid against exp_q.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic     clk;
  logic     reset;
  logic     scl_m, sda_m;
  i2c_dbg_t dbg;
  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h4B), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dbg_o (dbg)
  );

  // Open-drain bus: either side may pull SDA low.
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         n_pass = 0;
  int         n_total = 0;
  logic [8:0] exp_q[$];   // {rx_first, rx_data}
  logic [7:0] tx_q[$];    // bytes the fabric returns
  bit         fab_en = 1'b1;
  bit         oe_watch = 1'b0;
  int         rx_cnt = 0, start_cnt = 0, stop_cnt = 0, txreq_cnt = 0, oe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.start_det) start_cnt++;
      if (bus.stop_det) stop_cnt++;
      if (oe_watch && bus.sda_oe) oe_seen++;
      if (bus.rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected: got %0h expected none", {bus.rx_first, bus.rx_data});
        end else begin
          check("rx_byte", {23'd0, bus.rx_first, bus.rx_data}, {23'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- fabric responder ----------------
  initial begin
    logic [7:0] d;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.tx_req) begin
        txreq_cnt++;
        if (fab_en && tx_q.size() > 0) begin
          d = tx_q.pop_front();
          wait_clk(2);
          bus.tx_data  = d;
          bus.tx_valid = 1'b1;
          @(negedge clk);
          bus.tx_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- master driver tasks ----------------
  task automatic do_start();
    if (!scl_m) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b, input bit glitch);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(1);
      scl_m = 1'b1; wait_clk(Q - 1);
    end else begin
      wait_clk(2 * Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = bus.sda_in;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_idx, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_idx);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic nack);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    write_bit(nack, 1'b0);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    logic       ack, bt;
    logic [7:0] rd;
    int         s0, p0, r0, t0;

    scl_m = 1'b1;
    sda_m = 1'b1;
    reset = 1'b1;
    wait_clk(4);
    check("rst_sda_oe",    bus.sda_oe,    0);
    check("rst_rx_data",   bus.rx_data,   0);
    check("rst_rx_valid",  bus.rx_valid,  0);
    check("rst_rx_first",  bus.rx_first,  0);
    check("rst_tx_req",    bus.tx_req,    0);
    check("rst_busy",      bus.busy,      0);
    check("rst_start_det", bus.start_det, 0);
    check("rst_stop_det",  bus.stop_det,  0);
    check("rst_state",     32'(dbg.state), 32'(IDLE));
    reset = 1'b0;
    wait_clk(4);

    // 1: write E5 to 0x4B
    s0 = start_cnt; p0 = stop_cnt;
    do_start();
    check("t1_start_det", start_cnt - s0, 1);
    send_byte({7'h4B, I2C_RW_WRITE}, -1, ack);
    check("t1_addr_ack", ack, 0);
    check("t1_busy", bus.busy, 1);
    exp_q.push_back({1'b1, 8'hE5});
    send_byte(8'hE5, -1, ack);
    check("t1_data_ack", ack, 0);
    do_stop();
    check("t1_stop_det", stop_cnt - p0, 1);
    check("t1_busy_end", bus.busy, 0);

    // 2: wrong address -> NACK, SDA never driven
    r0 = rx_cnt;
    oe_watch = 1'b1;
    do_start();
    send_byte({7'h4A, I2C_RW_WRITE}, -1, ack);
    check("t2_addr_nack", ack, 1);
    send_byte(8'h55, -1, ack);
    check("t2_data_nack", ack, 1);
    do_stop();
    oe_watch = 1'b0;
    check("t2_oe_never", oe_seen, 0);
    check("t2_no_rx", rx_cnt - r0, 0);
    check("t2_busy", bus.busy, 0);

    // 3: pointer write, repeated START, read 2 bytes
    tx_q.push_back(8'h19);
    tx_q.push_back(8'h80);
    t0 = txreq_cnt;
    do_start();
    send_byte({7'h4B, I2C_RW_WRITE}, -1, ack);
    check("t3_waddr_ack", ack, 0);
    exp_q.push_back({1'b1, 8'h00});
    send_byte(8'h00, -1, ack);
    check("t3_ptr_ack", ack, 0);
    s0 = start_cnt;
    do_start();
    check("t3_rstart_det", start_cnt - s0, 1);
    send_byte({7'h4B, I2C_RW_READ}, -1, ack);
    check("t3_raddr_ack", ack, 0);
    recv_byte(rd, 1'b0);
    check("t3_rd0", rd, 8'h19);
    recv_byte(rd, 1'b1);
    check("t3_rd1", rd, 8'h80);
    check("t3_sda_released", bus.sda_oe, 0);
    do_stop();
    check("t3_tx_req_cnt", txreq_cnt - t0, 2);

    // 4: fabric silent -> FF, then a normal write still works
    fab_en = 1'b0;
    t0 = txreq_cnt;
    do_start();
    send_byte({7'h4B, I2C_RW_READ}, -1, ack);
    check("t4_raddr_ack", ack, 0);
    recv_byte(rd, 1'b1);
    check("t4_rd_ff", rd, 8'hFF);
    do_stop();
    check("t4_tx_req_cnt", txreq_cnt - t0, 1);
    fab_en = 1'b1;
    do_start();
    send_byte({7'h4B, I2C_RW_WRITE}, -1, ack);
    check("t4_waddr_ack", ack, 0);
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C, -1, ack);
    check("t4_data_ack", ack, 0);
    do_stop();

    // 5: reset while the target drives a 0 data bit
    tx_q.push_back(8'h00);
    do_start();
    send_byte({7'h4B, I2C_RW_READ}, -1, ack);
    check("t5_raddr_ack", ack, 0);
    read_bit(bt);
    check("t5_bit7", bt, 0);
    read_bit(bt);
    check("t5_bit6", bt, 0);
    wait_clk(Q);
    check("t5_oe_driving", bus.sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_oe_after_rst", bus.sda_oe, 0);
    check("t5_busy_after_rst", bus.busy, 0);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(Q);
    do_stop();
    check("t5_state_idle", 32'(dbg.state), 32'(IDLE));
    check("t5_oe_idle", bus.sda_oe, 0);
    do_start();
    send_byte({7'h4B, I2C_RW_WRITE}, -1, ack);
    check("t5_waddr_ack", ack, 0);
    exp_q.push_back({1'b1, 8'hA5});
    send_byte(8'hA5, -1, ack);
    check("t5_d0_ack", ack, 0);
    exp_q.push_back({1'b0, 8'h5A});
    send_byte(8'h5A, -1, ack);
    check("t5_d1_ack", ack, 0);
    do_stop();
    check("t5_busy_end", bus.busy, 0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // 6: one-cycle SCL low glitch inside a data bit is filtered out
    do_start();
    send_byte({7'h4B, I2C_RW_WRITE}, -1, ack);
    check("t6_waddr_ack", ack, 0);
    exp_q.push_back({1'b1, 8'hC3});
    send_byte(8'hC3, 4, ack);
    check("t6_data_ack", ack, 0);
    do_stop();
`endif

    wait_clk(4 * Q);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
